avg_handshake_fifo: RTL and testbench

- Elastic buffer stage directly downstream of the 4-channel averaging unit.
- Consumes 8-bit averages over the team's dav_/rfd handshake, in the consumer role.
- Queues them in a small synchronous FIFO.
- Re-emits them to the next consumer over an identical dav_/rfd handshake, in the producer role.
- Decouples the averager's conversion cycle from a slow downstream reader.

---
 rtl/avg_handshake_fifo_pkg.sv | 32 +++
 rtl/avg_handshake_fifo_sync_fifo_mem.sv | 80 ++++++++
 rtl/avg_handshake_fifo.sv | 127 ++++++++++++
 tb/tb_avg_handshake_fifo.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_handshake_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : avg_handshake_fifo_pkg
// Brief    : Shared state encodings, defaults and sizing helper for the
//            averager output elastic buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package avg_handshake_fifo_pkg;

    localparam int c_DEFAULT_DEPTH = 4;
    localparam int c_DEFAULT_W     = 8;

    typedef enum logic [0:0] {
        I_WAIT = 1'b0,
        I_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_WLO  = 2'd1,
        O_WHI  = 2'd2
    } out_state_t;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/avg_handshake_fifo_sync_fifo_mem.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_mem
// Brief    : Register-array FIFO store with pointers and registered occupancy.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_mem
    import avg_handshake_fifo_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int W     = c_DEFAULT_W,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int            AW           = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_full;
    logic          r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({push, pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage is left uninitialised; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/avg_handshake_fifo.sv
//------------------------------------------------------------------------------
// Module   : avg_handshake_fifo
// Brief    : dav_/rfd consumer -> FIFO -> dav_/rfd producer elastic buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module avg_handshake_fifo
    import avg_handshake_fifo_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int W     = c_DEFAULT_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dav_in_,
    input  logic [W-1:0]                  data_in,
    output logic                          rfd_out,
    output logic                          dav_out_,
    output logic [W-1:0]                  data_out,
    input  logic                          rfd_in,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int CW = count_width(DEPTH);

    in_state_t  r_in_state;
    in_state_t  w_in_next;
    out_state_t r_out_state;
    out_state_t w_out_next;

    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_rdata;
    logic         r_rfd_out;
    logic         r_dav_out_;
    logic [W-1:0] r_data_out;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W),
        .CW    (CW)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data_in),
        .rdata (w_rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Upstream side: the registered full flag gates acceptance, so a
    // same-cycle pop never lets a write through one cycle early.
    always_comb begin
        w_in_next = r_in_state;
        w_push    = 1'b0;
        case (r_in_state)
            I_WAIT: begin
                if (!dav_in_ && !full) begin
                    w_push    = 1'b1;
                    w_in_next = I_ACK;
                end
            end
            I_ACK: begin
                if (dav_in_) begin
                    w_in_next = I_WAIT;
                end
            end
            default: w_in_next = I_WAIT;
        endcase
    end

    always_comb begin
        w_out_next = r_out_state;
        w_pop      = 1'b0;
        case (r_out_state)
            O_IDLE: begin
                if (!empty && rfd_in) begin
                    w_pop      = 1'b1;
                    w_out_next = O_WLO;
                end
            end
            O_WLO: begin
                if (!rfd_in) begin
                    w_out_next = O_WHI;
                end
            end
            O_WHI: begin
                if (rfd_in) begin
                    w_out_next = O_IDLE;
                end
            end
            default: w_out_next = O_IDLE;
        endcase
    end

    // Handshake outputs are decoded from next state so they leave flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_state  <= I_WAIT;
            r_out_state <= O_IDLE;
            r_rfd_out   <= 1'b1;
            r_dav_out_  <= 1'b1;
            r_data_out  <= '0;
        end else begin
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            r_rfd_out   <= (w_in_next == I_WAIT);
            r_dav_out_  <= (w_out_next != O_WLO);
            if (w_pop) begin
                r_data_out <= w_rdata;
            end
        end
    end

    assign rfd_out  = r_rfd_out;
    assign dav_out_ = r_dav_out_;
    assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_avg_handshake_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_avg_handshake_fifo
// Brief    : Self-checking bench for avg_handshake_fifo with queue scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_avg_handshake_fifo;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          dav_in_ = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          rfd_out;
    logic          dav_out_;
    logic [W-1:0]  data_out;
    logic          rfd_in;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream model: manual level, or an automatic 4-phase consumer.
    bit           ds_enable = 1'b0;
    logic         ds_level  = 1'b1;
    logic         rfd_auto  = 1'b1;
    int           ds_min    = 0;
    int           ds_max    = 2;
    int           ds_phase  = 0;
    int           ds_delay  = 0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    assign rfd_in = ds_enable ? rfd_auto : ds_level;

    avg_handshake_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .dav_in_  (dav_in_),
        .data_in  (data_in),
        .rfd_out  (rfd_out),
        .dav_out_ (dav_out_),
        .data_out (data_out),
        .rfd_in   (rfd_in),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1;
        if (!ds_enable || reset) begin
            rfd_auto = 1'b1;
            ds_phase = 0;
        end else begin
            case (ds_phase)
                0: if (dav_out_ == 1'b0) begin
                    got_q.push_back(data_out);
                    ds_delay = int'($urandom_range(ds_max, ds_min));
                    ds_phase = 1;
                end
                1: if (ds_delay == 0) begin
                    rfd_auto = 1'b0;
                    ds_phase = 2;
                end else begin
                    ds_delay--;
                end
                default: if (dav_out_ == 1'b1) begin
                    rfd_auto = 1'b1;
                    ds_phase = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full upstream 4-phase transfer; the value joins the expected stream.
    task automatic send(input logic [W-1:0] v, input int gap);
        int t;
        repeat (gap) tick();
        exp_q.push_back(v);
        data_in = v;
        dav_in_ = 1'b0;
        t = 0;
        do begin tick(); t++; end while (rfd_out !== 1'b0 && t < 200);
        n_checks++;
        if (rfd_out !== 1'b0) begin
            n_fail++;
            $display("FAIL send_ack value=%02h rfd_out=%b required 0", v, rfd_out);
        end
        dav_in_ = 1'b1;
        t = 0;
        do begin tick(); t++; end while (rfd_out !== 1'b1 && t < 200);
        n_checks++;
        if (rfd_out !== 1'b1) begin
            n_fail++;
            $display("FAIL send_release value=%02h rfd_out=%b required 1", v, rfd_out);
        end
    endtask

    task automatic test_reset();
        int t;
        reset = 1'b1; dav_in_ = 1'b1; ds_enable = 1'b0; ds_level = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({rfd_out, dav_out_, data_out} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs rfd_out=%b dav_out_=%b data_out=%02h required 1 1 00", rfd_out, dav_out_, data_out);
        end
        n_checks++;
        if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_status count=%0d empty=%b full=%b required 0 1 0", count, empty, full);
        end
        reset = 1'b0; ds_level = 1'b0;
        tick();
        data_in = 8'h12; dav_in_ = 1'b0;
        t = 0;
        do begin tick(); t++; end while (rfd_out !== 1'b0 && t < 20);
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_pre_capture count=%0d required 1", count);
        end
        reset = 1'b1; dav_in_ = 1'b1;
        tick();
        n_checks++;
        if ({rfd_out, dav_out_, data_out, count, empty, full} !== {1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_midxfer rfd=%b dav=%b data=%02h count=%0d empty=%b full=%b required 1 1 00 0 1 0",
                     rfd_out, dav_out_, data_out, count, empty, full);
        end
        reset = 1'b0;
        got_q.delete();
        ds_enable = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_discard emitted=%0d required 0", got_q.size());
        end
        ds_enable = 1'b0; ds_level = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        ds_enable = 1'b0; ds_level = 1'b1;
        data_in = 8'h5A; dav_in_ = 1'b0;
        tick();
        n_checks++;
        if ({rfd_out, dav_out_, count} !== {1'b0, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL single_capture rfd_out=%b dav_out_=%b count=%0d required 0 1 1", rfd_out, dav_out_, count);
        end
        dav_in_ = 1'b1;
        tick();
        n_checks++;
        if ({dav_out_, data_out, rfd_out, count} !== {1'b0, 8'h5A, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL single_emit dav_out_=%b data_out=%02h rfd_out=%b count=%0d required 0 5a 1 0",
                     dav_out_, data_out, rfd_out, count);
        end
        ds_level = 1'b0;
        tick();
        n_checks++;
        if (dav_out_ !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release dav_out_=%b required 1", dav_out_);
        end
        ds_level = 1'b1;
        tick();
        n_checks++;
        if ({count, empty, dav_out_, data_out} !== {3'd0, 1'b1, 1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL single_done count=%0d empty=%b dav_out_=%b data_out=%02h required 0 1 1 5a",
                     count, empty, dav_out_, data_out);
        end
    endtask

    task automatic test_fill_stall();
        int  t;
        bit  stalled_ok;
        got_q.delete(); exp_q.delete();
        ds_enable = 1'b0; ds_level = 1'b0; ds_min = 0; ds_max = 2;
        for (int i = 1; i <= DEPTH; i++) send(W'(i), 0);
        n_checks++;
        if ({full, count} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL fill_full full=%b count=%0d required 1 4", full, count);
        end
        exp_q.push_back(8'h05);
        data_in = 8'h05; dav_in_ = 1'b0;
        stalled_ok = 1'b1;
        repeat (5) begin tick(); if (rfd_out !== 1'b1) stalled_ok = 1'b0; end
        n_checks++;
        if (!stalled_ok) begin
            n_fail++;
            $display("FAIL fill_stall rfd_out dropped while full, required held at 1");
        end
        ds_enable = 1'b1;
        t = 0;
        do begin tick(); t++; end while (rfd_out !== 1'b0 && t < 100);
        n_checks++;
        if (rfd_out !== 1'b0 || got_q.size() < 1 || got_q[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL fill_accept rfd_out=%b emitted=%0d required 0 after first emit of 01", rfd_out, got_q.size());
        end
        n_checks++;
        if ({count, full} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_refill count=%0d full=%b required 4 1", count, full);
        end
        dav_in_ = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin tick(); t++; end
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fill_drain emitted=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fill_order idx=%0d got=%02h required %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        ds_enable = 1'b0; ds_level = 1'b1;
    endtask

    task automatic test_wrap();
        int t;
        got_q.delete(); exp_q.delete();
        ds_min = 0; ds_max = 1; ds_enable = 1'b1;
        for (int i = 0; i < 10; i++) send(W'(8'hA0 + i), int'($urandom_range(0, 2)));
        t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin tick(); t++; end
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_drain emitted=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_order idx=%0d got=%02h required %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++;
        if ({count, empty, dav_out_} !== {3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_idle count=%0d empty=%b dav_out_=%b required 0 1 1", count, empty, dav_out_);
        end
        ds_enable = 1'b0; ds_level = 1'b1;
    endtask

    task automatic test_simultaneous();
        int t;
        got_q.delete(); exp_q.delete();
        ds_enable = 1'b0; ds_level = 1'b0; ds_min = 0; ds_max = 2;
        send(8'hB1, 0);
        send(8'hB2, 0);
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_setup count=%0d required 2", count);
        end
        exp_q.push_back(8'hB3);
        data_in = 8'hB3; dav_in_ = 1'b0; ds_level = 1'b1;
        tick();
        n_checks++;
        if ({count, rfd_out, dav_out_, data_out} !== {3'd2, 1'b0, 1'b0, 8'hB1}) begin
            n_fail++;
            $display("FAIL simul_pushpop count=%0d rfd_out=%b dav_out_=%b data_out=%02h required 2 0 0 b1",
                     count, rfd_out, dav_out_, data_out);
        end
        dav_in_ = 1'b1;
        ds_enable = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin tick(); t++; end
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL simul_drain emitted=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL simul_order idx=%0d got=%02h required %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        ds_enable = 1'b0; ds_level = 1'b1;
    endtask

    task automatic test_slow_downstream();
        int           t;
        bit           stable;
        logic [W-1:0] held;
        got_q.delete(); exp_q.delete();
        ds_enable = 1'b0; ds_level = 1'b1; ds_min = 0; ds_max = 2;
        send(8'hC0, 0);
        t = 0;
        while (dav_out_ !== 1'b0 && t < 20) begin tick(); t++; end
        held = data_out;
        stable = (dav_out_ === 1'b0);
        // Downstream withholds its acknowledge (rfd_in stays 1) for 20 cycles.
        fork
            begin
                for (int i = 1; i <= DEPTH; i++) send(W'(8'hC0 + i), 0);
            end
            begin
                repeat (20) begin
                    tick();
                    if (dav_out_ !== 1'b0 || data_out !== held) stable = 1'b0;
                end
            end
        join
        n_checks++;
        if (!stable || held !== 8'hC0) begin
            n_fail++;
            $display("FAIL slow_hold dav_out_=%b data_out=%02h held=%02h required 0 c0 stable", dav_out_, data_out, held);
        end
        n_checks++;
        if ({full, count} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL slow_fill full=%b count=%0d required 1 4", full, count);
        end
        ds_enable = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin tick(); t++; end
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL slow_drain emitted=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL slow_order idx=%0d got=%02h required %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        ds_enable = 1'b0; ds_level = 1'b1;
    endtask

    task automatic test_random();
        int t;
        got_q.delete(); exp_q.delete();
        ds_min = 0; ds_max = 4; ds_enable = 1'b1;
        for (int i = 0; i < 30; i++) send(W'($urandom), int'($urandom_range(0, 3)));
        t = 0;
        while (got_q.size() < exp_q.size() && t < 1000) begin tick(); t++; end
        repeat (10) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_drain emitted=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_order idx=%0d got=%02h required %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++;
        if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL random_idle count=%0d empty=%b full=%b required 0 1 0", count, empty, full);
        end
        ds_enable = 1'b0; ds_level = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill_stall();
        test_wrap();
        test_simultaneous();
        test_slow_downstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
